// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
// FSM encodings and port indices used by the top and its arbiter.
package sram_port_arbiter_pkg;

  localparam int DATA_W_DEF = 4;
  localparam int ADDR_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/sram_port_arbiter_rr_arbiter2.sv
// Two-way round-robin grant logic, purely combinational.
// On a tie the port that did not win last time is granted.
module rr_arbiter2
  import sram_port_arbiter_pkg::*;
(
  input  logic [1:0] valid_i,
  input  logic       last_grant_i,
  input  logic       enable_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = 2'b00;
    if (enable_i) begin
      unique case (valid_i)
        2'b01:   grant_o = 2'b01;
        2'b10:   grant_o = 2'b10;
        2'b11:   grant_o = (last_grant_i == PORT1) ? 2'b01 : 2'b10;
        default: grant_o = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one async-read SRAM between two ports.
// Accept, one access cycle, one response cycle per transaction.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e            state_q;
  logic              last_q;
  logic              gidx_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;

  logic [1:0]        grant;
  logic              we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;

  rr_arbiter2 u_arb (
    .valid_i      ({req1_valid, req0_valid}),
    .last_grant_i (last_q),
    .enable_i     (rst_n && (state_q == ST_IDLE)),
    .grant_o      (grant)
  );

  // Mux only the granted port so mem_* never sees the loser's inputs.
  always_comb begin
    we_d    = grant[1] ? req1_we    : req0_we;
    addr_d  = grant[1] ? req1_addr  : req0_addr;
    wdata_d = grant[1] ? req1_wdata : req0_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      last_q   <= PORT1;
      gidx_q   <= PORT0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (|grant) begin
            gidx_q  <= grant[1];
            last_q  <= grant[1];
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            state_q <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (!we_q) begin
            if (gidx_q == PORT1) rdata1_q <= mem_rdata;
            else                 rdata0_q <= mem_rdata;
          end
          state_q <= ST_DONE;
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  // Gated by rst_n so a reset cycle can never write the SRAM.
  assign mem_cs    = rst_n && (state_q == ST_ACCESS);
  assign mem_we    = mem_cs && we_q;
  assign mem_addr  = rst_n ? addr_q  : '0;
  assign mem_wdata = rst_n ? wdata_q : '0;

  assign rsp0_valid = rst_n && (state_q == ST_DONE) && (gidx_q == PORT0);
  assign rsp1_valid = rst_n && (state_q == ST_DONE) && (gidx_q == PORT1);
  assign rsp0_rdata = rst_n ? rdata0_q : '0;
  assign rsp1_rdata = rst_n ? rdata1_q : '0;

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one 16x4 cascaded SRAM (two 8x4 banks, bank chosen by addr MSB) between two requesters, port 0 and port 1.
- Each port issues single-word read/write requests over a valid/ready handshake.
- The arbiter grants round-robin, sequences the SRAM chip-select/write-enable for one access cycle, and returns a registered response per port.
- Sits between client logic and the cascaded SRAM; the SRAM read path is combinational (asynchronous).

Parameters:
- DATA_W, 4, data word width (matches SRAM width).
- ADDR_W, 4, SRAM address width; MSB is the bank select inside the SRAM.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req0_valid  in  1  port 0 request present.
- req0_ready  out  1  port 0 request accepted this cycle.
- req0_we  in  1  port 0: 1 = write, 0 = read.
- req0_addr  in  ADDR_W  port 0 address.
- req0_wdata  in  DATA_W  port 0 write data.
- rsp0_valid  out  1  one-cycle pulse: port 0 transaction complete.
- rsp0_rdata  out  DATA_W  port 0 read data, valid with rsp0_valid on reads.
- req1_valid, req1_ready, req1_we, req1_addr, req1_wdata, rsp1_valid, rsp1_rdata: same as port 0, for port 1.
- mem_cs  out  1  SRAM chip select.
- mem_we  out  1  SRAM write enable.
- mem_addr  out  ADDR_W  SRAM address.
- mem_wdata  out  DATA_W  SRAM write data.
- mem_rdata  in  DATA_W  SRAM combinational read data.

Behaviour:
- Clocking and reset: one clock, clk; reset rst_n is synchronous, active-low.
- Values held while rst_n=0:
  - state=IDLE, last_grant=1 (port 0 wins the first tie).
  - All req*_ready, rsp*_valid, mem_cs, mem_we = 0.
  - rsp*_rdata = 0.
  - mem_addr and mem_wdata = 0.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If any reqN_valid: grant one port; reqN_ready=1 for that port only, combinationally in the same cycle.
  - Latch we/addr/wdata and the granted index; go to ACCESS.
  - No valid: stay in IDLE; ready=0 on both ports.
- ACCESS, exactly one cycle:
  - mem_cs=1, mem_we=latched we, mem_addr/mem_wdata from the latch.
  - On a read, capture mem_rdata at the clock edge into the granted port's rsp_rdata register.
  - Go to DONE.
- DONE, one cycle:
  - rspN_valid=1 for the granted port only.
  - On a write, rspN_rdata holds its previous value.
  - Go to IDLE.
- Latency and throughput:
  - Accept at cycle T, memory access at T+1, rsp_valid at T+2.
  - Next accept at the earliest T+3, so at most one transaction per 3 cycles.
- Arbitration:
  - Only one valid: that port wins.
  - Both valid: the port != last_grant wins.
  - last_grant updates only on an accept.
- Outside ACCESS: mem_cs=0 and mem_we=0. mem_addr and mem_wdata hold their last value, with no glitching to the other port's inputs.
- Requesters must keep valid/we/addr/wdata stable until ready. Dropping valid before ready is legal; that request is simply not taken.
- Reset mid-operation:
  - mem_cs and mem_we are gated by rst_n, so no write occurs in a reset cycle.
  - An in-flight transaction is dropped with no rsp_valid; the next cycle is IDLE.
- Ready is never asserted to both ports in the same cycle; rsp_valid is never asserted to both ports in the same cycle.
- The arbiter performs no address decoding; the SRAM selects the bank from addr MSB.

Decomposition:
- Shared package: DATA_W/ADDR_W defaults, FSM state encodings (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2), port index constants.
- One sub-module: rr_arbiter2.
  - Inputs: valid[1:0], last_grant, enable.
  - Outputs: one-hot grant[1:0].
  - Purely combinational; last_grant register stays in the top.

Test Plan:
- Reset, then port 0 writes addr 4'hA data 4'h5 → req0_ready at T, mem_cs=1/mem_we=1/mem_addr=A/mem_wdata=5 at T+1, rsp0_valid pulse at T+2.
- Port 1 reads addr 4'hA after the previous write → rsp1_valid at T+2 with rsp1_rdata=4'h5; rsp0_valid stays 0.
- Both ports hold valid continuously, writing addr 3 and addr B → grants alternate 0,1,0,1 at accept cycles T, T+3, T+6, T+9; never both ready.
- Write data 4'h9 to addr 4'h2 and 4'h6 to addr 4'hA, then read both → 9 and 6 returned, confirming bank separation through the cascaded SRAM.
- rst_n=0 during ACCESS of a write to addr 4'h1 (prior contents 4'h0) → mem_cs=0 that cycle, no rsp_valid, state IDLE, later read of addr 1 returns 4'h0, first post-reset tie grants port 0.
- Port 0 valid drops before any accept while port 1 is busy → no port 0 transaction, no port 0 rsp_valid.
